nmt_decode_execute: RTL and testbench
=====================================

# nmt_decode_execute

Decode/execute slice of the five-stage NMT pipeline, sitting between the IF/ID stage and the memory stage. It decodes a 32-bit instruction and reads a 32×32 register file that the write-back stage updates. It then executes the instruction in an ALU, and presents the results through an EX/MEM pipeline register. It also produces a thread address for NMT (thread) operations, computed from the memory-controller address lines.

## Interface
- No parameters. Data width is fixed at 32 bits, the register file at 32 entries, and controller addresses at 9 bits.
- `clk` in 1: the single clock; everything is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 32: instruction from IF/ID.
- `pc_i` in 32: PC of `instr`.
- `ALU_output` in 32: write-back ALU result.
- `reg_dst_in` in 5: write-back destination register.
- `LMD_output` in 32: write-back load data.
- `mem_write` in 1: write `LMD_output` to `reg_dst_in`.
- `alu_write` in 1: write `ALU_output` to `reg_dst_in`.
- `control_cmd` in 1: host request, 1 = write, 0 = read.
- `address` in 9: address currently used by the memory controller.
- `freed_address` in 9: address just released by the controller.
- `alu_o` out 32: registered ALU result.
- `instr_o` out 32: registered instruction.
- `opcode_o` out 6: registered opcode.
- `cond_o` out 1: registered branch-taken / NMT-collision flag.
- `reg_dst_o` out 5: registered destination register.
- `reg2_o` out 32: registered rt value (store data).
- `mem_write_o` out 1: registered load write-back enable.
- `alu_write_o` out 1: registered ALU write-back enable.
- `cmd_type_o` out 3: registered command class.
- `thread_address` out 32: registered NMT thread address.

## Operation
- Instruction fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0] (sign-extended), funct [5:0], shamt [10:6].
- cmd_type encoding:
  - 0 = NOP, 1 = R-type, 2 = I-type ALU, 3 = LOAD, 4 = STORE, 5 = BRANCH, 6 = NMT.
- Opcode and funct assignments:
  - Opcode 0x00 (R-type) uses funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, SLT 0x2A (signed), SLL 0x00, SRL 0x02 (shift rt by shamt).
  - ADDI 0x08, ANDI 0x0C, ORI 0x0D. ANDI/ORI zero-extend imm.
  - LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, NMT 0x3F.
  - Any other opcode or funct is a NOP.
- Destination register: rd for R-type; rt for I-type and LOAD. reg_dst is 0 for all other classes.
- Write-back enables: alu_write = 1 for R-type and I-type; mem_write = 1 for LOAD only. Both are 0 for all other classes.
- ALU result by class:
  - LOAD/STORE: rs + sext(imm).
  - BRANCH: pc + 4 + (sext(imm) << 2).
  - NMT: {23'b0, address}.
  - NOP: 0.
- cond by class:
  - BEQ: rs == rt.
  - BNE: rs != rt.
  - NMT: control_cmd & (address != freed_address).
  - All other classes: 0.
- thread_address: loads {24'b0, address[7:0]} only when an NMT instruction is registered into EX/MEM; otherwise it holds its value.
- Register file:
  - r0 always reads 0 and is never written.
  - Written on the rising edge when `mem_write` or `alu_write` is 1. If both are 1, `LMD_output` wins.
  - Reads are combinational, with write-through: a read of the register being written this cycle returns the new value.
- Arithmetic wraps modulo 2^32. No overflow detection.

## Timing
- The decode/register-read result is captured in an internal ID/EX register on the rising edge.
- The ALU is combinational from the ID/EX register. All outputs are captured in the EX/MEM register on the next rising edge.
- Latency is 2 clocks from `instr` to the outputs. Throughput is one instruction per clock. There is no stall or flush input.
- Reset: asynchronous while `rst_n` = 0.
  - Clears the ID/EX and EX/MEM registers, all outputs and all 32 registers to 0. The cleared pipeline is equivalent to NOPs.
  - Reset asserted mid-operation discards in-flight instructions.
  - The first instruction after release reaches the outputs 2 edges later.
- Write-back vs read in the same cycle: the instruction decoded in that cycle sees the written value.

## Test plan
- Reset, then write back r1 = 5 and r2 = 3 (alu_write = 1). Issue ADD r3,r1,r2 (0x00221820). 2 clocks later: alu_o = 8, reg_dst_o = 3, alu_write_o = 1, cmd_type_o = 1.
- With r1 = 5, r2 = 3: SUB gives 2; SLT r1,r2 gives 0. Set r1 = 0xFFFFFFFF, then ADDI r4,r1,1 gives alu_o = 0 (wrap).
- LW r5,8(r1) with r1 = 0x100: alu_o = 0x108, mem_write_o = 1, reg_dst_o = 5. SW with rt = r2 = 3: reg2_o = 3, both write enables 0.
- BEQ r1,r1,+4 at pc = 0x40: cond_o = 1, alu_o = 0x54. BNE r1,r1: cond_o = 0.
- NMT with address = 0x1A5, freed_address = 0x0A0, control_cmd = 1: alu_o = 0x1A5, thread_address = 0xA5, cond_o = 1. Repeat with freed_address = 0x1A5: cond_o = 0.
- Assert `rst_n` low mid-stream: all outputs go to 0 immediately, without a clock edge. Simultaneous mem_write/alu_write to r6: r6 holds LMD_output; a write to r0 leaves r0 reading 0.

Source files
------------

// File: rtl/nmt_decode_execute.sv
// rtl/nmt_decode_execute.sv - NMT pipeline decode/execute slice with register file and EX/MEM register
module nmt_decode_execute (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] pc_i,
    input  logic [31:0] ALU_output,
    input  logic [4:0]  reg_dst_in,
    input  logic [31:0] LMD_output,
    input  logic        mem_write,
    input  logic        alu_write,
    input  logic        control_cmd,
    input  logic [8:0]  address,
    input  logic [8:0]  freed_address,
    output logic [31:0] alu_o,
    output logic [31:0] instr_o,
    output logic [5:0]  opcode_o,
    output logic        cond_o,
    output logic [4:0]  reg_dst_o,
    output logic [31:0] reg2_o,
    output logic        mem_write_o,
    output logic        alu_write_o,
    output logic [2:0]  cmd_type_o,
    output logic [31:0] thread_address
);
    localparam logic [2:0] CMD_NOP = 3'd0, CMD_R = 3'd1, CMD_I = 3'd2, CMD_LOAD = 3'd3,
                           CMD_STORE = 3'd4, CMD_BRANCH = 3'd5, CMD_NMT = 3'd6;

    logic [31:0] regs [32];
    logic        wb_en;
    logic [31:0] wb_data;
    logic [4:0]  rs, rt;
    logic [31:0] rs_val, rt_val;
    logic [2:0]  dec_cmd;
    logic [4:0]  dec_dst;

    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign wb_en   = (mem_write || alu_write) && (reg_dst_in != 5'd0);
    assign wb_data = mem_write ? LMD_output : ALU_output;

    // Write-through so the instruction decoded this cycle sees the write-back value
    assign rs_val = (rs == 5'd0) ? 32'd0 : (wb_en && rs == reg_dst_in) ? wb_data : regs[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : (wb_en && rt == reg_dst_in) ? wb_data : regs[rt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[reg_dst_in] <= wb_data;
        end
    end

    always_comb begin
        dec_cmd = CMD_NOP;
        case (instr[31:26])
            6'h00: begin
                case (instr[5:0])
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02: dec_cmd = CMD_R;
                    default: dec_cmd = CMD_NOP;
                endcase
            end
            6'h08, 6'h0C, 6'h0D: dec_cmd = CMD_I;
            6'h23:               dec_cmd = CMD_LOAD;
            6'h2B:               dec_cmd = CMD_STORE;
            6'h04, 6'h05:        dec_cmd = CMD_BRANCH;
            6'h3F:               dec_cmd = CMD_NMT;
            default:             dec_cmd = CMD_NOP;
        endcase
    end

    always_comb begin
        dec_dst = 5'd0;
        case (dec_cmd)
            CMD_R:           dec_dst = instr[15:11];
            CMD_I, CMD_LOAD: dec_dst = rt;
            default:         dec_dst = 5'd0;
        endcase
    end

    // ID/EX register
    logic [2:0]  idex_cmd;
    logic [31:0] idex_instr, idex_a, idex_b, idex_pc;
    logic [8:0]  idex_addr, idex_freed;
    logic        idex_ctrl;
    logic [4:0]  idex_dst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_cmd   <= CMD_NOP;
            idex_instr <= '0;
            idex_a     <= '0;
            idex_b     <= '0;
            idex_pc    <= '0;
            idex_addr  <= '0;
            idex_freed <= '0;
            idex_ctrl  <= 1'b0;
            idex_dst   <= '0;
        end else begin
            idex_cmd   <= dec_cmd;
            idex_instr <= instr;
            idex_a     <= rs_val;
            idex_b     <= rt_val;
            idex_pc    <= pc_i;
            idex_addr  <= address;
            idex_freed <= freed_address;
            idex_ctrl  <= control_cmd;
            idex_dst   <= dec_dst;
        end
    end

    logic [31:0] imm_sx, imm_zx, ex_result;
    logic [4:0]  shamt;
    logic        ex_cond;

    assign imm_sx = {{16{idex_instr[15]}}, idex_instr[15:0]};
    assign imm_zx = {16'd0, idex_instr[15:0]};
    assign shamt  = idex_instr[10:6];

    always_comb begin
        ex_result = 32'd0;
        ex_cond   = 1'b0;
        case (idex_cmd)
            CMD_R: begin
                case (idex_instr[5:0])
                    6'h20:   ex_result = idex_a + idex_b;
                    6'h22:   ex_result = idex_a - idex_b;
                    6'h24:   ex_result = idex_a & idex_b;
                    6'h25:   ex_result = idex_a | idex_b;
                    6'h26:   ex_result = idex_a ^ idex_b;
                    6'h2A:   ex_result = {31'd0, $signed(idex_a) < $signed(idex_b)};
                    6'h00:   ex_result = idex_b << shamt;
                    6'h02:   ex_result = idex_b >> shamt;
                    default: ex_result = 32'd0;
                endcase
            end
            CMD_I: begin
                case (idex_instr[31:26])
                    6'h0C:   ex_result = idex_a & imm_zx;
                    6'h0D:   ex_result = idex_a | imm_zx;
                    default: ex_result = idex_a + imm_sx;
                endcase
            end
            CMD_LOAD, CMD_STORE: ex_result = idex_a + imm_sx;
            CMD_BRANCH: begin
                ex_result = idex_pc + 32'd4 + (imm_sx << 2);
                ex_cond   = (idex_instr[26] == 1'b0) ? (idex_a == idex_b) : (idex_a != idex_b);
            end
            CMD_NMT: begin
                ex_result = {23'd0, idex_addr};
                ex_cond   = idex_ctrl && (idex_addr != idex_freed);
            end
            default: begin
                ex_result = 32'd0;
                ex_cond   = 1'b0;
            end
        endcase
    end

    // EX/MEM register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_o          <= '0;
            instr_o        <= '0;
            opcode_o       <= '0;
            cond_o         <= 1'b0;
            reg_dst_o      <= '0;
            reg2_o         <= '0;
            mem_write_o    <= 1'b0;
            alu_write_o    <= 1'b0;
            cmd_type_o     <= CMD_NOP;
            thread_address <= '0;
        end else begin
            alu_o       <= ex_result;
            instr_o     <= idex_instr;
            opcode_o    <= idex_instr[31:26];
            cond_o      <= ex_cond;
            reg_dst_o   <= idex_dst;
            reg2_o      <= idex_b;
            mem_write_o <= (idex_cmd == CMD_LOAD);
            alu_write_o <= (idex_cmd == CMD_R) || (idex_cmd == CMD_I);
            cmd_type_o  <= idex_cmd;
            if (idex_cmd == CMD_NMT) thread_address <= {24'd0, idex_addr[7:0]};
        end
    end
endmodule

// File: tb/tb_nmt_decode_execute.sv
// tb/tb_nmt_decode_execute.sv - self-checking bench for nmt_decode_execute
module tb_nmt_decode_execute;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr, pc_i, ALU_output, LMD_output;
    logic [4:0]  reg_dst_in;
    logic        mem_write, alu_write, control_cmd;
    logic [8:0]  address, freed_address;
    logic [31:0] alu_o, instr_o, reg2_o, thread_address;
    logic [5:0]  opcode_o;
    logic        cond_o, mem_write_o, alu_write_o;
    logic [4:0]  reg_dst_o;
    logic [2:0]  cmd_type_o;

    nmt_decode_execute dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .pc_i(pc_i), .ALU_output(ALU_output),
        .reg_dst_in(reg_dst_in), .LMD_output(LMD_output), .mem_write(mem_write),
        .alu_write(alu_write), .control_cmd(control_cmd), .address(address),
        .freed_address(freed_address), .alu_o(alu_o), .instr_o(instr_o), .opcode_o(opcode_o),
        .cond_o(cond_o), .reg_dst_o(reg_dst_o), .reg2_o(reg2_o), .mem_write_o(mem_write_o),
        .alu_write_o(alu_write_o), .cmd_type_o(cmd_type_o), .thread_address(thread_address)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP_I = 32'h0400_0000;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] ins;
        logic [5:0]  op;
        logic        cond;
        logic [4:0]  dst;
        logic [31:0] reg2;
        logic        mw;
        logic        aw;
        logic [2:0]  cmd;
        logic [31:0] thr;
    } exp_t;

    logic [31:0] m_regs [32];
    exp_t        exp_id, exp_ex;
    logic [31:0] exp_thread;
    int          errors = 0;
    int          checks = 0;

    logic [112:0] dut_vec;
    assign dut_vec = {alu_o, instr_o, opcode_o, cond_o, reg_dst_o, reg2_o, mem_write_o, alu_write_o, cmd_type_o};

    function automatic logic [112:0] pack_exp(input exp_t e);
        return {e.alu, e.ins, e.op, e.cond, e.dst, e.reg2, e.mw, e.aw, e.cmd};
    endfunction

    // Final EX/MEM contents of one instruction, computed straight from the ISA rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [8:0] addr, input logic [8:0] freed, input logic ctrl);
        exp_t e;
        logic [31:0] sx, zx;
        e      = '0;
        e.ins  = ins;
        e.op   = ins[31:26];
        e.reg2 = b;
        e.thr  = {24'd0, addr[7:0]};
        sx     = 32'($signed(ins[15:0]));
        zx     = {16'd0, ins[15:0]};
        case (ins[31:26])
            6'h00: begin
                e.cmd = 3'd1; e.aw = 1'b1; e.dst = ins[15:11];
                case (ins[5:0])
                    6'h20: e.alu = a + b;
                    6'h22: e.alu = a - b;
                    6'h24: e.alu = a & b;
                    6'h25: e.alu = a | b;
                    6'h26: e.alu = a ^ b;
                    6'h2A: e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h00: e.alu = b << ins[10:6];
                    6'h02: e.alu = b >> ins[10:6];
                    default: begin e.cmd = 3'd0; e.aw = 1'b0; e.dst = 5'd0; end
                endcase
            end
            6'h08: begin e.cmd = 3'd2; e.aw = 1'b1; e.dst = ins[20:16]; e.alu = a + sx; end
            6'h0C: begin e.cmd = 3'd2; e.aw = 1'b1; e.dst = ins[20:16]; e.alu = a & zx; end
            6'h0D: begin e.cmd = 3'd2; e.aw = 1'b1; e.dst = ins[20:16]; e.alu = a | zx; end
            6'h23: begin e.cmd = 3'd3; e.mw = 1'b1; e.dst = ins[20:16]; e.alu = a + sx; end
            6'h2B: begin e.cmd = 3'd4; e.alu = a + sx; end
            6'h04: begin e.cmd = 3'd5; e.alu = pc + 32'd4 + sx * 32'd4; e.cond = (a == b); end
            6'h05: begin e.cmd = 3'd5; e.alu = pc + 32'd4 + sx * 32'd4; e.cond = (a != b); end
            6'h3F: begin e.cmd = 3'd6; e.alu = 32'(addr); e.cond = ctrl && (addr != freed); end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        exp_id = '0; exp_ex = '0; exp_thread = '0;
    endtask

    task automatic idle_inputs();
        instr = NOP_I; pc_i = '0; ALU_output = '0; LMD_output = '0; reg_dst_in = '0;
        mem_write = 1'b0; alu_write = 1'b0; control_cmd = 1'b0; address = '0; freed_address = '0;
    endtask

    // One rising edge; the model tracks the pipeline, then returns at the falling edge
    task automatic step();
        @(posedge clk);
        if ((mem_write || alu_write) && reg_dst_in != 5'd0)
            m_regs[reg_dst_in] = mem_write ? LMD_output : ALU_output;
        exp_ex = exp_id;
        if (exp_ex.cmd == 3'd6) exp_thread = exp_ex.thr;
        exp_id = model(instr, pc_i, m_regs[instr[25:21]], m_regs[instr[20:16]],
                       address, freed_address, control_cmd);
        @(negedge clk);
    endtask

    task automatic wb(input int r, input logic [31:0] v);
        alu_write = 1'b1; reg_dst_in = 5'(r); ALU_output = v; instr = NOP_I;
        step();
        alu_write = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins);
        instr = ins;
        step();
        instr = NOP_I;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        clear_model();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec !== '0 || thread_address !== 32'd0) begin
            errors++; $display("FAIL reset_outputs got=%h/%h exp=0", dut_vec, thread_address);
        end
    endtask

    task automatic test_add();
        wb(1, 32'd5); wb(2, 32'd3);
        issue(32'h0022_1820);
        checks++;
        if (alu_o !== 32'd8 || reg_dst_o !== 5'd3 || alu_write_o !== 1'b1 || cmd_type_o !== 3'd1) begin
            errors++; $display("FAIL add got alu=%h dst=%0d aw=%b cmd=%0d exp 8/3/1/1", alu_o, reg_dst_o, alu_write_o, cmd_type_o);
        end
        checks++;
        if (dut_vec !== pack_exp(exp_ex)) begin errors++; $display("FAIL add_model got=%h exp=%h", dut_vec, pack_exp(exp_ex)); end
    endtask

    task automatic test_alu();
        issue(r_ins(1, 2, 3, 0, 6'h22));
        checks++;
        if (alu_o !== 32'd2) begin errors++; $display("FAIL sub got=%h exp=2", alu_o); end
        issue(r_ins(1, 2, 3, 0, 6'h2A));
        checks++;
        if (alu_o !== 32'd0) begin errors++; $display("FAIL slt got=%h exp=0", alu_o); end
        wb(1, 32'hFFFF_FFFF);
        issue(i_ins(6'h08, 1, 4, 16'd1));
        checks++;
        if (alu_o !== 32'd0 || reg_dst_o !== 5'd4 || cmd_type_o !== 3'd2) begin
            errors++; $display("FAIL addi_wrap got alu=%h dst=%0d cmd=%0d exp 0/4/2", alu_o, reg_dst_o, cmd_type_o);
        end
        checks++;
        if (dut_vec !== pack_exp(exp_ex)) begin errors++; $display("FAIL addi_model got=%h exp=%h", dut_vec, pack_exp(exp_ex)); end
    endtask

    task automatic test_mem();
        wb(1, 32'h100);
        issue(i_ins(6'h23, 1, 5, 16'd8));
        checks++;
        if (alu_o !== 32'h108 || mem_write_o !== 1'b1 || reg_dst_o !== 5'd5 || alu_write_o !== 1'b0) begin
            errors++; $display("FAIL lw got alu=%h mw=%b dst=%0d aw=%b exp 108/1/5/0", alu_o, mem_write_o, reg_dst_o, alu_write_o);
        end
        issue(i_ins(6'h2B, 1, 2, 16'd0));
        checks++;
        if (reg2_o !== 32'd3 || mem_write_o !== 1'b0 || alu_write_o !== 1'b0 || cmd_type_o !== 3'd4 || alu_o !== 32'h100) begin
            errors++; $display("FAIL sw got reg2=%h mw=%b aw=%b cmd=%0d alu=%h exp 3/0/0/4/100", reg2_o, mem_write_o, alu_write_o, cmd_type_o, alu_o);
        end
    endtask

    task automatic test_branch();
        pc_i = 32'h40;
        issue(i_ins(6'h04, 1, 1, 16'd4));
        checks++;
        if (cond_o !== 1'b1 || alu_o !== 32'h54 || cmd_type_o !== 3'd5 || reg_dst_o !== 5'd0) begin
            errors++; $display("FAIL beq got cond=%b alu=%h cmd=%0d dst=%0d exp 1/54/5/0", cond_o, alu_o, cmd_type_o, reg_dst_o);
        end
        issue(i_ins(6'h05, 1, 1, 16'd4));
        checks++;
        if (cond_o !== 1'b0 || alu_o !== 32'h54) begin errors++; $display("FAIL bne got cond=%b alu=%h exp 0/54", cond_o, alu_o); end
        pc_i = '0;
    endtask

    task automatic test_nmt();
        address = 9'h1A5; freed_address = 9'h0A0; control_cmd = 1'b1;
        issue(32'hFC00_0000);
        checks++;
        if (alu_o !== 32'h1A5 || thread_address !== 32'hA5 || cond_o !== 1'b1 || cmd_type_o !== 3'd6) begin
            errors++; $display("FAIL nmt got alu=%h thr=%h cond=%b cmd=%0d exp 1a5/a5/1/6", alu_o, thread_address, cond_o, cmd_type_o);
        end
        freed_address = 9'h1A5;
        issue(32'hFC00_0000);
        checks++;
        if (cond_o !== 1'b0 || thread_address !== 32'hA5) begin
            errors++; $display("FAIL nmt_nocollide got cond=%b thr=%h exp 0/a5", cond_o, thread_address);
        end
        address = 9'h033;
        issue(NOP_I);
        checks++;
        if (thread_address !== 32'hA5 || cmd_type_o !== 3'd0 || alu_o !== 32'd0) begin
            errors++; $display("FAIL thread_hold got thr=%h cmd=%0d alu=%h exp a5/0/0", thread_address, cmd_type_o, alu_o);
        end
        idle_inputs();
    endtask

    task automatic test_writeback();
        mem_write = 1'b1; alu_write = 1'b1; reg_dst_in = 5'd6;
        LMD_output = 32'hAAAA_0001; ALU_output = 32'h5555_0002;
        step();
        mem_write = 1'b0; alu_write = 1'b0;
        issue(r_ins(6, 0, 7, 0, 6'h20));
        checks++;
        if (alu_o !== 32'hAAAA_0001) begin errors++; $display("FAIL wb_both got=%h exp=aaaa0001", alu_o); end
        wb(0, 32'h1234);
        issue(r_ins(0, 0, 7, 0, 6'h25));
        checks++;
        if (alu_o !== 32'd0) begin errors++; $display("FAIL r0_write got=%h exp=0", alu_o); end
        alu_write = 1'b1; reg_dst_in = 5'd8; ALU_output = 32'h0BAD_F00D;
        instr = r_ins(8, 0, 9, 0, 6'h20);
        step();
        alu_write = 1'b0; instr = NOP_I;
        step();
        checks++;
        if (alu_o !== 32'h0BAD_F00D) begin errors++; $display("FAIL write_through got=%h exp=0badf00d", alu_o); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [10];
        logic [5:0] fns [9];
        logic [31:0] ins;
        ops = '{6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02, 6'h3B};
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) != 0) ins[31:26] = ops[$urandom_range(0, 9)];
            if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 8)];
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            instr = ins;
            pc_i = $urandom & 32'hFFFF_FFFC;
            mem_write = ($urandom_range(0, 3) == 0);
            alu_write = $urandom_range(0, 1) == 1;
            reg_dst_in = 5'($urandom_range(0, 7));
            ALU_output = $urandom;
            LMD_output = $urandom;
            control_cmd = $urandom_range(0, 1) == 1;
            address = 9'($urandom);
            freed_address = ($urandom_range(0, 3) == 0) ? address : 9'($urandom);
            step();
            checks++;
            if (dut_vec !== pack_exp(exp_ex) || thread_address !== exp_thread) begin
                errors++;
                $display("FAIL b2b_%0d got=%h thr=%h exp=%h thr=%h", n, dut_vec, thread_address, pack_exp(exp_ex), exp_thread);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        wb(1, 32'd7);
        instr = r_ins(1, 1, 2, 0, 6'h20);
        step();
        instr = i_ins(6'h23, 1, 3, 16'd4);
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== '0 || thread_address !== 32'd0) begin
            errors++; $display("FAIL reset_async got=%h/%h exp=0", dut_vec, thread_address);
        end
        idle_inputs();
        @(negedge clk);
        clear_model();
        rst_n = 1'b1;
        instr = r_ins(1, 0, 4, 0, 6'h25);
        step();
        checks++;
        if (dut_vec !== '0) begin errors++; $display("FAIL reset_first_edge got=%h exp=0", dut_vec); end
        instr = NOP_I;
        step();
        checks++;
        if (alu_o !== 32'd0 || reg_dst_o !== 5'd4 || cmd_type_o !== 3'd1 || dut_vec !== pack_exp(exp_ex)) begin
            errors++; $display("FAIL reset_release got=%h exp=%h", dut_vec, pack_exp(exp_ex));
        end
    endtask

    initial begin
        idle_inputs();
        clear_model();
        test_reset();
        test_add();
        test_alu();
        test_mem();
        test_branch();
        test_nmt();
        test_writeback();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
